// File: rtl/inst_mem_responder.sv
// -----------------------------------------------------------------------------
// inst_mem_responder
//
// Memory-side responder for the core's instruction fetch interface. Fetch
// requests are accepted into an in-order circular queue, forwarded one at a
// time to a backing read port (grant + variable latency), and the returned
// words are handed back to the fetch pipeline in request order. A flush drops
// every request not yet sent to memory and marks every request already sent
// as "discard" so its data is swallowed when it eventually arrives.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   inst_req/_cache/_addr  fetch request from the core
//   inst_addr_ok       request accepted this cycle (combinational)
//   inst_rdata/_data_ok    returned instruction word and its valid strobe
//   flush              single-cycle cancel of all outstanding fetches
//   mem_req/_addr/_cache   backing read request, held until mem_gnt
//   mem_gnt            backing port accepts the request this cycle
//   mem_rvalid/_rdata  backing read data return
//   busy               at least one entry outstanding
//   perfcnt_discard    number of responses dropped because of a flush
// -----------------------------------------------------------------------------
module inst_mem_responder #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_cache,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_data_ok,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_cache,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [31:0] perfcnt_discard
);

    // Pointers carry one extra wrap bit so that tail - head distinguishes
    // a full queue from an empty one; the low PTR_W bits index the entries.
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0]   tail_q, tail_d;
    logic [PTR_W:0]   iss_q, iss_d;
    logic [PTR_W:0]   head_q, head_d;
    logic [31:0]      perf_q, perf_d;
    logic [31:0]      addr_q [DEPTH];
    logic [DEPTH-1:0] cache_q;
    logic [DEPTH-1:0] disc_q;

    logic [PTR_W-1:0] tail_idx_s, iss_idx_s, head_idx_s;
    logic [PTR_W:0]   count_s;
    logic             acc_s, mem_req_s, grant_s, ret_s, drop_s, data_ok_s;

    // Handshake decode and next-state pointer / counter computation.
    always_comb begin
        tail_idx_s = tail_q[PTR_W-1:0];
        iss_idx_s  = iss_q[PTR_W-1:0];
        head_idx_s = head_q[PTR_W-1:0];
        count_s    = tail_q - head_q;

        // Acceptance uses the registered count, so a same-cycle retire never
        // frees a slot for the request presented in that cycle.
        acc_s      = inst_req && (count_s != DEPTH_C) && !flush;
        // Only entries accepted in earlier cycles are visible to issue.
        mem_req_s  = (iss_q != tail_q) && !flush;
        grant_s    = mem_req_s && mem_gnt;
        // Data with nothing issued is a protocol error and is ignored.
        ret_s      = mem_rvalid && (head_q != iss_q);
        drop_s     = ret_s && (disc_q[head_idx_s] || flush);
        data_ok_s  = ret_s && !disc_q[head_idx_s] && !flush;

        if (flush) begin
            tail_d = iss_q;
        end else begin
            tail_d = tail_q + {{PTR_W{1'b0}}, acc_s};
        end
        iss_d  = iss_q + {{PTR_W{1'b0}}, grant_s};
        head_d = head_q + {{PTR_W{1'b0}}, ret_s};

        if (drop_s) begin
            perf_d = perf_q + 32'd1;
        end else begin
            perf_d = perf_q;
        end
    end

    // Queue pointers and the discard performance counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tail_q <= '0;
            iss_q  <= '0;
            head_q <= '0;
            perf_q <= 32'd0;
        end else begin
            tail_q <= tail_d;
            iss_q  <= iss_d;
            head_q <= head_d;
            perf_q <= perf_d;
        end
    end

    // Entry storage: allocation writes the tail slot; flush marks every slot
    // discard. Free and dropped slots are rewritten with discard=0 on their
    // next allocation, so marking all of them is equivalent to marking only
    // the issued ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 32'd0;
            end
            cache_q <= '0;
            disc_q  <= '0;
        end else if (flush) begin
            disc_q <= '1;
        end else if (acc_s) begin
            addr_q[tail_idx_s]  <= inst_addr;
            cache_q[tail_idx_s] <= inst_cache;
            disc_q[tail_idx_s]  <= 1'b0;
        end else begin
            disc_q <= disc_q;
        end
    end

    // Output drive; address/attribute are zeroed while no request is shown.
    always_comb begin
        inst_addr_ok    = acc_s;
        inst_data_ok    = data_ok_s;
        mem_req         = mem_req_s;
        busy            = (count_s != '0);
        perfcnt_discard = perf_q;
        if (data_ok_s) begin
            inst_rdata = mem_rdata;
        end else begin
            inst_rdata = 32'd0;
        end
        if (mem_req_s) begin
            mem_addr  = addr_q[iss_idx_s];
            mem_cache = cache_q[iss_idx_s];
        end else begin
            mem_addr  = 32'd0;
            mem_cache = 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_cache, flush, mem_gnt, mem_rvalid;
    logic [31:0] inst_addr, mem_rdata;
    logic        inst_addr_ok, inst_data_ok, mem_req, mem_cache, busy;
    logic [31:0] inst_rdata, mem_addr, perfcnt_discard;

    int          vec_cnt  = 0;
    int          miss_cnt = 0;
    logic [31:0] exp_perf = 32'd0;

    always #5 clk = ~clk;

    inst_mem_responder #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_cache(mem_cache),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .perfcnt_discard(perfcnt_discard)
    );

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0; inst_cache = 1'b0; inst_addr = 32'd0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #12;
        vec_cnt++;
        if ({inst_addr_ok, inst_data_ok, mem_req, busy} !== 4'b0000 || perfcnt_discard !== 32'd0 ||
            inst_rdata !== 32'd0 || mem_addr !== 32'd0) begin
            miss_cnt++;
            $display("FAIL reset_outputs got ok=%b dok=%b mreq=%b busy=%b perf=%h want all 0",
                     inst_addr_ok, inst_data_ok, mem_req, busy, perfcnt_discard);
        end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        // cycle 0: request accepted, not yet issued
        inst_req = 1'b1; inst_addr = 32'h1FC0_0000; inst_cache = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (inst_addr_ok !== 1'b1 || mem_req !== 1'b0) begin
            miss_cnt++; $display("FAIL single_accept got ok=%b mreq=%b want 1 0", inst_addr_ok, mem_req);
        end
        tick();
        // cycle 1: issued and granted
        inst_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1FC0_0000 || mem_cache !== 1'b1) begin
            miss_cnt++; $display("FAIL single_issue got mreq=%b addr=%h cache=%b want 1 1fc00000 1",
                                 mem_req, mem_addr, mem_cache);
        end
        tick();
        mem_gnt = 1'b0;
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            vec_cnt++;
            if (busy !== 1'b1 || mem_req !== 1'b0 || inst_data_ok !== 1'b0) begin
                miss_cnt++; $display("FAIL single_wait got busy=%b mreq=%b dok=%b want 1 0 0",
                                     busy, mem_req, inst_data_ok);
            end
            tick();
        end
        // cycle 4: data returns
        mem_rvalid = 1'b1; mem_rdata = 32'h3C08_BFC0;
        @(negedge clk);
        vec_cnt++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C08_BFC0) begin
            miss_cnt++; $display("FAIL single_data got dok=%b rdata=%h want 1 3c08bfc0", inst_data_ok, inst_rdata);
        end
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0) begin
            miss_cnt++; $display("FAIL single_idle got busy=%b want 0", busy);
        end
        tick();
    endtask

    task automatic test_full_queue();
        logic [31:0] a;
        for (int k = 0; k < 4; k++) begin
            inst_req = 1'b1; inst_addr = 32'(4 * k); inst_cache = 1'b0;
            @(negedge clk);
            vec_cnt++;
            if (inst_addr_ok !== 1'b1) begin
                miss_cnt++; $display("FAIL full_fill%0d got ok=%b want 1", k, inst_addr_ok);
            end
            tick();
        end
        // fifth request refused while full; grants do not free slots
        inst_addr = 32'h10;
        for (int k = 0; k < 6; k++) begin
            mem_gnt = (k >= 2);
            @(negedge clk);
            vec_cnt++;
            if (inst_addr_ok !== 1'b0 || busy !== 1'b1) begin
                miss_cnt++; $display("FAIL full_refuse%0d got ok=%b busy=%b want 0 1", k, inst_addr_ok, busy);
            end
            if (k >= 2) begin
                a = 32'(4 * (k - 2));
                vec_cnt++;
                if (mem_req !== 1'b1 || mem_addr !== a) begin
                    miss_cnt++; $display("FAIL full_issue%0d got mreq=%b addr=%h want 1 %h", k, mem_req, mem_addr, a);
                end
            end
            tick();
        end
        mem_gnt = 1'b0;
        // returns in order; first return cycle still refuses (registered count)
        for (int k = 0; k < 4; k++) begin
            a = 32'(4 * k);
            mem_rvalid = 1'b1; mem_rdata = a ^ 32'hA5A5_0000;
            inst_req = (k < 2);
            @(negedge clk);
            vec_cnt++;
            if (inst_data_ok !== 1'b1 || inst_rdata !== (a ^ 32'hA5A5_0000)) begin
                miss_cnt++; $display("FAIL full_ret%0d got dok=%b rdata=%h want 1 %h",
                                     k, inst_data_ok, inst_rdata, a ^ 32'hA5A5_0000);
            end
            if (k < 2) begin
                vec_cnt++;
                if (inst_addr_ok !== (k == 1)) begin
                    miss_cnt++; $display("FAIL full_reaccept%0d got ok=%b want %b", k, inst_addr_ok, k == 1);
                end
            end
            tick();
        end
        inst_req = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            miss_cnt++; $display("FAIL full_fifth_issue got mreq=%b addr=%h want 1 10", mem_req, mem_addr);
        end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0B10;
        @(negedge clk);
        vec_cnt++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0000_0B10) begin
            miss_cnt++; $display("FAIL full_fifth_data got dok=%b rdata=%h want 1 00000b10", inst_data_ok, inst_rdata);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_mid();
        inst_req = 1'b1; inst_addr = 32'h100;
        tick();
        inst_addr = 32'h104; mem_gnt = 1'b1;
        tick();
        inst_addr = 32'h108;
        @(negedge clk);
        vec_cnt++;
        if (mem_addr !== 32'h104 || inst_addr_ok !== 1'b1) begin
            miss_cnt++; $display("FAIL flush_setup got addr=%h ok=%b want 104 1", mem_addr, inst_addr_ok);
        end
        tick();
        // flush with a request presented: refused, nothing issued
        mem_gnt = 1'b1; flush = 1'b1; inst_addr = 32'h1F0;
        @(negedge clk);
        vec_cnt++;
        if (inst_addr_ok !== 1'b0 || mem_req !== 1'b0) begin
            miss_cnt++; $display("FAIL flush_cycle got ok=%b mreq=%b want 0 0", inst_addr_ok, mem_req);
        end
        tick();
        flush = 1'b0; inst_req = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (mem_req !== 1'b0) begin
            miss_cnt++; $display("FAIL flush_pending_dropped got mreq=%b addr=%h want 0", mem_req, mem_addr);
        end
        tick();
        mem_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0000 + 32'(k);
            @(negedge clk);
            vec_cnt++;
            if (inst_data_ok !== 1'b0 || inst_rdata !== 32'd0) begin
                miss_cnt++; $display("FAIL flush_discard%0d got dok=%b rdata=%h want 0 0", k, inst_data_ok, inst_rdata);
            end
            tick();
        end
        mem_rvalid = 1'b0;
        exp_perf = exp_perf + 32'd2;
        @(negedge clk);
        vec_cnt++;
        if (perfcnt_discard !== exp_perf || busy !== 1'b0) begin
            miss_cnt++; $display("FAIL flush_perf got perf=%0d busy=%b want %0d 0", perfcnt_discard, busy, exp_perf);
        end
        tick();
        inst_req = 1'b1; inst_addr = 32'h200;
        tick();
        inst_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
            miss_cnt++; $display("FAIL flush_after_issue got mreq=%b addr=%h want 1 200", mem_req, mem_addr);
        end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_0200;
        @(negedge clk);
        vec_cnt++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h2222_0200) begin
            miss_cnt++; $display("FAIL flush_after_data got dok=%b rdata=%h want 1 22220200", inst_data_ok, inst_rdata);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_coincident();
        inst_req = 1'b1; inst_addr = 32'h300;
        tick();
        inst_req = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
        inst_req = 1'b1; inst_addr = 32'h304;
        @(negedge clk);
        vec_cnt++;
        if (inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b0 || inst_rdata !== 32'd0) begin
            miss_cnt++; $display("FAIL coinc_cycle got ok=%b dok=%b rdata=%h want 0 0 0",
                                 inst_addr_ok, inst_data_ok, inst_rdata);
        end
        tick();
        idle_inputs();
        exp_perf = exp_perf + 32'd1;
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0 || perfcnt_discard !== exp_perf || mem_req !== 1'b0) begin
            miss_cnt++; $display("FAIL coinc_after got busy=%b perf=%0d mreq=%b want 0 %0d 0",
                                 busy, perfcnt_discard, mem_req, exp_perf);
        end
        tick();
    endtask

    task automatic test_wrap_stress();
        logic [31:0] pend[$];
        logic [31:0] issq[$];
        logic [31:0] g;
        int          sent   = 0;
        int          cycles = 0;
        logic        exp_ok, exp_mreq, do_gnt;
        while ((sent < 100 || pend.size() + issq.size() > 0) && cycles < 5000) begin
            inst_req   = (sent < 100) && ($urandom_range(0, 3) != 0);
            inst_addr  = 32'h1000 + 32'(4 * sent);
            inst_cache = inst_addr[2];
            mem_gnt    = ($urandom_range(0, 2) != 0);
            mem_rvalid = (issq.size() > 0) && ($urandom_range(0, 2) == 0);
            mem_rdata  = (issq.size() > 0) ? (issq[0] ^ 32'hDEAD_BEEF) : 32'd0;
            exp_ok     = inst_req && (pend.size() + issq.size() < 4);
            exp_mreq   = (pend.size() > 0);
            @(negedge clk);
            vec_cnt++;
            if (inst_addr_ok !== exp_ok || mem_req !== exp_mreq || busy !== (pend.size() + issq.size() > 0)) begin
                miss_cnt++; $display("FAIL stress_ctl c%0d got ok=%b mreq=%b busy=%b want %b %b %b", cycles,
                                     inst_addr_ok, mem_req, busy, exp_ok, exp_mreq, pend.size() + issq.size() > 0);
            end
            if (exp_mreq) begin
                vec_cnt++;
                if (mem_addr !== pend[0]) begin
                    miss_cnt++; $display("FAIL stress_addr c%0d got %h want %h", cycles, mem_addr, pend[0]);
                end
            end
            if (mem_rvalid) begin
                vec_cnt++;
                if (inst_data_ok !== 1'b1 || inst_rdata !== (issq[0] ^ 32'hDEAD_BEEF)) begin
                    miss_cnt++; $display("FAIL stress_data c%0d got dok=%b rdata=%h want 1 %h", cycles,
                                         inst_data_ok, inst_rdata, issq[0] ^ 32'hDEAD_BEEF);
                end
            end else begin
                vec_cnt++;
                if (inst_data_ok !== 1'b0) begin
                    miss_cnt++; $display("FAIL stress_nodata c%0d got dok=%b want 0", cycles, inst_data_ok);
                end
            end
            do_gnt = exp_mreq && mem_gnt;
            g = do_gnt ? pend.pop_front() : 32'd0;
            if (mem_rvalid) begin
                void'(issq.pop_front());
            end
            if (do_gnt) begin
                issq.push_back(g);
            end
            if (exp_ok) begin
                pend.push_back(inst_addr);
                sent++;
            end
            tick();
            cycles++;
        end
        idle_inputs();
        vec_cnt++;
        if (cycles >= 5000) begin
            miss_cnt++; $display("FAIL stress_timeout sent=%0d outstanding=%0d want 100 0",
                                 sent, pend.size() + issq.size());
        end
        tick();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            inst_req = 1'b1; inst_addr = 32'h500 + 32'(4 * k);
            mem_gnt = (k == 1);
            tick();
        end
        inst_req = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        #2;
        resetn = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        #1;
        vec_cnt++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || inst_data_ok !== 1'b0 || perfcnt_discard !== 32'd0) begin
            miss_cnt++; $display("FAIL async_reset got busy=%b mreq=%b dok=%b perf=%0d want 0 0 0 0",
                                 busy, mem_req, inst_data_ok, perfcnt_discard);
        end
        tick();
        resetn = 1'b1; mem_rvalid = 1'b0;
        tick();
        inst_req = 1'b1; inst_addr = 32'h400; inst_cache = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (inst_addr_ok !== 1'b1 || mem_req !== 1'b0) begin
            miss_cnt++; $display("FAIL async_after_accept got ok=%b mreq=%b want 1 0", inst_addr_ok, mem_req);
        end
        tick();
        inst_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_cache !== 1'b1) begin
            miss_cnt++; $display("FAIL async_after_issue got mreq=%b addr=%h cache=%b want 1 400 1",
                                 mem_req, mem_addr, mem_cache);
        end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h4444_0400;
        @(negedge clk);
        vec_cnt++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h4444_0400) begin
            miss_cnt++; $display("FAIL async_after_data got dok=%b rdata=%h want 1 44440400", inst_data_ok, inst_rdata);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_full_queue();
        test_flush_mid();
        test_flush_coincident();
        test_wrap_stress();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Memory-side responder for the core's instruction fetch interface (inst_req / inst_addr / inst_addr_ok).
- Accepts fetch requests into an in-order outstanding queue and forwards them to a backing read port that has a grant and variable latency.
- Returns fetched words to the fetch pipeline on inst_rdata / inst_data_ok, in request order.
- A flush, pulsed by the core on exception commit or redirect, drops requests not yet sent to memory and discards data still owed for requests already sent.

Parameters:
- DEPTH, 4, number of outstanding-request entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request valid
- inst_cache  in  1  request is cacheable
- inst_addr  in  32  physical fetch address
- inst_addr_ok  out  1  request accepted this cycle
- inst_rdata  out  32  returned instruction word
- inst_data_ok  out  1  inst_rdata valid this cycle
- flush  in  1  cancel all outstanding fetches
- mem_req  out  1  backing read request valid
- mem_addr  out  32  backing read address
- mem_cache  out  1  cacheable attribute for backing read
- mem_gnt  in  1  backing port accepts mem_req this cycle
- mem_rvalid  in  1  backing read data valid
- mem_rdata  in  32  backing read data
- busy  out  1  queue count != 0
- perfcnt_discard  out  32  count of responses dropped due to flush

Behaviour:
- Reset: asynchronous on resetn low. Clears all pointers, the count, every valid/discard bit, and perfcnt_discard. All outputs are 0 during and after reset until a request arrives.
- Queue: circular buffer of DEPTH entries, each holding {addr, cache, discard}.
- Pointers: tail (allocate), iss (next entry to send to memory), head (oldest entry awaiting data).
- Entry ordering: entries in [head, iss) are issued; entries in [iss, tail) are pending.
- count = tail - head, kept in PTR_W+1 bits so that full and empty are distinguishable.
- Accept: inst_addr_ok = inst_req && count != DEPTH && !flush (combinational, same cycle). On accept, write the entry at tail with discard=0, then tail++.
- Issue: mem_req = (iss != tail) && !flush. mem_addr and mem_cache come from entry[iss]. On mem_req && mem_gnt, iss++.
- mem_req/mem_addr hold stable until granted.
- Accept-to-mem_req latency is 1 cycle minimum; a request is never issued in its own accept cycle.
- Return path: on mem_rvalid with head != iss, the response belongs to entry[head].
  - inst_data_ok = mem_rvalid && !entry[head].discard && !flush.
  - inst_rdata = mem_rdata (combinational passthrough; 0 whenever inst_data_ok is 0).
  - head++ on every mem_rvalid with head != iss.
  - If that response is dropped (discard=1 or flush high), perfcnt_discard is incremented, wrapping at 2^32.
- mem_rvalid while head == iss is a protocol error: ignored, no state change, inst_data_ok=0.
- Flush (single-cycle pulse, may repeat):
  - Sets tail <= iss (all pending entries dropped).
  - Sets discard=1 on every issued entry.
  - If mem_gnt is sampled high that cycle, mem_req is 0 by rule, so there is no grant.
  - A mem_rvalid arriving in the flush cycle is consumed and dropped.
  - No new request is accepted in the flush cycle.
- Simultaneous events:
  - Accept, grant and rvalid in the same cycle are all legal. Pointers update independently and count = count + acc - ret.
  - A full queue with a same-cycle retire still refuses the request, because inst_addr_ok is based on the registered count.
- Ordering guarantee: inst_data_ok pulses occur in request-acceptance order, exactly one per accepted and unflushed request.
- Wrap-around: all pointers wrap modulo DEPTH. The extra count bit handles full vs empty.
- busy = count != 0, registered-state based.

Test Plan:
- Single fetch: req addr 0x1FC00000 cache=1 at cycle 0 -> inst_addr_ok=1 cycle 0; mem_req at cycle 1 with addr 0x1FC00000 mem_cache=1; gnt at cycle 1, rvalid at cycle 4 with 0x3C08BFC0 -> inst_data_ok=1, inst_rdata=0x3C08BFC0 at cycle 4; busy=0 at cycle 5.
- Full queue, DEPTH=4, mem_gnt held 0: 5 back-to-back reqs (addr 0x0,0x4,0x8,0xC,0x10) -> first 4 accepted, 5th sees inst_addr_ok=0 until the first rvalid; order returned 0x0,0x4,0x8,0xC.
- Flush mid-flight: 2 issued (0x100,0x104) and 1 pending (0x108), then flush -> 0x108 is never requested; both rvalids give inst_data_ok=0; perfcnt_discard=2; next req 0x200 returns normally.
- Flush coincident with rvalid and req: flush, mem_rvalid and inst_req all high in one cycle -> inst_addr_ok=0, inst_data_ok=0, head advances, perfcnt_discard +1.
- Wrap-around stress: 100 random reqs with random gnt/rvalid latency 0-5 -> scoreboard confirms in-order data, no loss or duplication, count never exceeds 4.
- Async reset mid-operation: assert resetn low between clock edges with 3 outstanding -> busy, mem_req, inst_data_ok and perfcnt_discard are 0 immediately; after release a new req is served at 1-cycle issue latency.
